// File: rtl/fsab_stream_reader.sv
// Streams burst_count FSAB read bursts from a 64-byte aligned address into a local FIFO.
// Requests are gated by the FSAB credit count and by FIFO space reserved for data still in flight.
module fsab_stream_reader #(
    parameter int FSAB_MY_DID  = 3,
    parameter int FIFO_DEPTH   = 32,
    parameter int INIT_CREDITS = 4,
    parameter int BURST_WORDS  = 8,
    parameter int FSAB_ADDR_HI = 30,
    parameter int FSAB_DATA_HI = 63,
    parameter int FSAB_DID_HI  = 4,
    parameter int FSAB_LEN_HI  = 6,
    parameter int FSAB_MASK_HI = 7
) (
    input  logic                    fsabi_clk,
    input  logic                    rst_b,
    input  logic                    start,
    input  logic [FSAB_ADDR_HI:0]   start_addr,
    input  logic [15:0]             burst_count,
    output logic                    busy,
    output logic                    done,
    output logic                    fsabo_valid,
    output logic                    fsabo_mode,
    output logic [FSAB_DID_HI:0]    fsabo_did,
    output logic [FSAB_DID_HI:0]    fsabo_subdid,
    output logic [FSAB_ADDR_HI:0]   fsabo_addr,
    output logic [FSAB_LEN_HI:0]    fsabo_len,
    output logic [FSAB_DATA_HI:0]   fsabo_data,
    output logic [FSAB_MASK_HI:0]   fsabo_mask,
    input  logic                    fsabo_credit,
    input  logic                    fsabi_valid,
    input  logic [FSAB_DID_HI:0]    fsabi_did,
    input  logic [FSAB_DID_HI:0]    fsabi_subdid,
    input  logic [FSAB_DATA_HI:0]   fsabi_data,
    output logic                    out_valid,
    output logic [FSAB_DATA_HI:0]   out_data,
    input  logic                    out_ready
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam int   AW        = $clog2(FIFO_DEPTH);
    localparam int   CW        = AW + 1;
    localparam int   BW        = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam int   KW        = $clog2(INIT_CREDITS + 1);
    localparam logic FSAB_READ = 1'b0;

    state_t                state, state_nxt;
    logic                  done_nxt;
    logic [15:0]           total_bursts, bursts_issued, bursts_done;
    logic [BW-1:0]         beat_cnt;
    logic [FSAB_ADDR_HI:0] req_addr;
    logic [KW-1:0]         credits;
    logic [CW-1:0]         inflight, fifo_count;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [FSAB_DATA_HI:0] mem [FIFO_DEPTH];
    logic                  start_ok, room, issue, accept, pop, burst_end, last_beat;
    logic                  unused_bits;

    assign unused_bits = ^{fsabi_subdid, start_addr[5:0]};

    assign start_ok  = start && (state == IDLE) && !done;
    // Space is reserved at request time, so every accepted beat always finds a free slot.
    assign room      = ({1'b0, fifo_count} + {1'b0, inflight} + (CW+1)'(BURST_WORDS))
                       <= (CW+1)'(FIFO_DEPTH);
    assign issue     = (state == ISSUE) && (credits != '0) && room && (bursts_issued != total_bursts);
    assign accept    = fsabi_valid && (fsabi_did == (FSAB_DID_HI+1)'(FSAB_MY_DID)) && (inflight != '0);
    assign pop       = out_valid && out_ready;
    assign burst_end = accept && (beat_cnt == BW'(BURST_WORDS - 1));
    assign last_beat = burst_end && (bursts_done == total_bursts - 16'd1);
    assign busy      = (state != IDLE) || done;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: if (start_ok) begin
                if (burst_count == 16'd0) done_nxt = 1'b1;
                else                      state_nxt = ISSUE;
            end
            ISSUE: if (issue && (bursts_issued + 16'd1 == total_bursts)) state_nxt = WAIT;
            WAIT: if (last_beat) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fsabo_valid  = issue;
        fsabo_mode   = FSAB_READ;
        fsabo_did    = '0;
        fsabo_subdid = '0;
        fsabo_addr   = '0;
        fsabo_len    = '0;
        fsabo_data   = '0;
        fsabo_mask   = '0;
        if (issue) begin
            fsabo_did    = (FSAB_DID_HI+1)'(FSAB_MY_DID);
            fsabo_subdid = bursts_issued[FSAB_DID_HI:0];
            fsabo_addr   = req_addr;
            fsabo_len    = (FSAB_LEN_HI+1)'(BURST_WORDS);
        end
    end

    always_ff @(posedge fsabi_clk or negedge rst_b) begin
        if (!rst_b) begin
            state         <= IDLE;
            done          <= 1'b0;
            total_bursts  <= '0;
            bursts_issued <= '0;
            bursts_done   <= '0;
            beat_cnt      <= '0;
            req_addr      <= '0;
            credits       <= KW'(INIT_CREDITS);
            inflight      <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (start_ok) begin
                total_bursts  <= burst_count;
                bursts_issued <= '0;
                bursts_done   <= '0;
                beat_cnt      <= '0;
                req_addr      <= {start_addr[FSAB_ADDR_HI:6], 6'b0};
            end else if (issue) begin
                bursts_issued <= bursts_issued + 16'd1;
                req_addr      <= req_addr + (FSAB_ADDR_HI+1)'(BURST_WORDS * 8);
            end
            if (accept) begin
                beat_cnt <= burst_end ? '0 : beat_cnt + BW'(1);
                if (burst_end) bursts_done <= bursts_done + 16'd1;
            end
            // A credit returned in the same cycle as a request cancels out.
            if (issue && !fsabo_credit)
                credits <= credits - KW'(1);
            else if (!issue && fsabo_credit && (credits < KW'(INIT_CREDITS)))
                credits <= credits + KW'(1);
            inflight <= inflight + (issue ? CW'(BURST_WORDS) : '0) - (accept ? CW'(1) : '0);
        end
    end

    always_ff @(posedge fsabi_clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            if (accept && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (pop && !accept) fifo_count <= fifo_count - CW'(1);
        end
    end

    always_ff @(posedge fsabi_clk) begin
        if (accept) mem[wr_ptr] <= fsabi_data;
    end

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fsab_stream_reader.sv
// Directed bench for fsab_stream_reader: a memory responder feeds return beats while
// request and output monitors pop expected queues filled by the stimulus.
module tb_fsab_stream_reader;
    localparam int AW = 31;
    localparam int DW = 64;
    localparam int IW = 5;
    localparam int LW = 7;
    localparam int MW = 8;
    localparam int DEPTH = 32;

    logic          fsabi_clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [15:0]   burst_count = '0;
    logic          busy, done;
    logic          fsabo_valid, fsabo_mode;
    logic [IW-1:0] fsabo_did, fsabo_subdid;
    logic [AW-1:0] fsabo_addr;
    logic [LW-1:0] fsabo_len;
    logic [DW-1:0] fsabo_data;
    logic [MW-1:0] fsabo_mask;
    logic          fsabo_credit = 1'b0;
    logic          fsabi_valid = 1'b0;
    logic [IW-1:0] fsabi_did = '0;
    logic [IW-1:0] fsabi_subdid = '0;
    logic [DW-1:0] fsabi_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;

    fsab_stream_reader dut (
        .fsabi_clk(fsabi_clk), .rst_b(rst_b), .start(start), .start_addr(start_addr),
        .burst_count(burst_count), .busy(busy), .done(done),
        .fsabo_valid(fsabo_valid), .fsabo_mode(fsabo_mode), .fsabo_did(fsabo_did),
        .fsabo_subdid(fsabo_subdid), .fsabo_addr(fsabo_addr), .fsabo_len(fsabo_len),
        .fsabo_data(fsabo_data), .fsabo_mask(fsabo_mask), .fsabo_credit(fsabo_credit),
        .fsabi_valid(fsabi_valid), .fsabi_did(fsabi_did), .fsabi_subdid(fsabi_subdid),
        .fsabi_data(fsabi_data), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready)
    );

    always #5 fsabi_clk = ~fsabi_clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int req_seen = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [IW-1:0] exp_sub_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pend_q[$];
    int  credit_grant = 0, credit_sent = 0, auto_pend = 0;
    int  same_req = 0, same_done = 0;
    bit  auto_credit = 1'b0, junk_mode = 1'b0, stale_mode = 1'b0, junk_tog = 1'b0;
    int  resp_budget = 1000000, resp_sent = 0;
    int  last_beat_cyc = -100;
    logic [DW-1:0] data_seq = 64'hA5A5_0000_0000_0000;

    always @(posedge fsabi_clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: event not expected or not seen in time", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge fsabi_clk);
        #2;
    endtask

    // Memory responder: queues 8 beats per request, returns credits, drives return beats.
    always begin
        @(negedge fsabi_clk);
        if (fsabo_valid === 1'b1 && rst_b === 1'b1) begin
            for (int b = 0; b < 8; b++) begin
                pend_q.push_back(data_seq);
                data_seq = data_seq + 64'h1_0001;
            end
            if (auto_credit) auto_pend++;
            if (same_done < same_req) begin
                fsabo_credit = 1'b1;
                same_done++;
            end
        end
        @(posedge fsabi_clk);
        #1;
        fsabo_credit = 1'b0;
        if (credit_sent < credit_grant) begin
            fsabo_credit = 1'b1;
            credit_sent++;
        end else if (auto_pend > 0) begin
            fsabo_credit = 1'b1;
            auto_pend--;
        end
        fsabi_valid = 1'b0;
        fsabi_did   = '0;
        fsabi_data  = '0;
        if (junk_mode && junk_tog) begin
            fsabi_valid = 1'b1;
            fsabi_did   = 5'd5;
            fsabi_data  = 64'hDEAD_BEEF_0000_0000 | 64'(cyc);
        end else if (pend_q.size() > 0 && resp_sent < resp_budget) begin
            fsabi_valid = 1'b1;
            fsabi_did   = 5'd3;
            fsabi_data  = pend_q.pop_front();
            resp_sent++;
            if (!stale_mode) begin
                exp_q.push_back(fsabi_data);
                last_beat_cyc = cyc;
                check("fifo_bound", 64'(exp_q.size() <= DEPTH + 1), 64'd1);
            end
        end
        junk_tog = ~junk_tog;
    end

    // Request monitor.
    always @(negedge fsabi_clk) begin
        if (rst_b === 1'b1) begin
            if (fsabo_valid === 1'b1) begin
                req_seen++;
                if (exp_addr_q.size() == 0) fail_now("req_unexpected");
                else begin
                    check("req_addr", 64'(fsabo_addr), 64'(exp_addr_q.pop_front()));
                    check("req_subdid", 64'(fsabo_subdid), 64'(exp_sub_q.pop_front()));
                    check("req_fields", {fsabo_mode, fsabo_did, fsabo_len, fsabo_mask},
                          {1'b0, 5'd3, 7'd8, 8'd0});
                    check("req_data", fsabo_data, 64'd0);
                end
            end else begin
                check("req_idle_zero", 64'({fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr,
                      fsabo_len, fsabo_mask}) | fsabo_data, 64'd0);
            end
        end
    end

    // Output monitor.
    always @(negedge fsabi_clk) begin
        if (rst_b === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) fail_now("out_unexpected");
            else check("out_data", out_data, exp_q.pop_front());
        end
    end

    task automatic do_start(input logic [AW-1:0] addr, input logic [15:0] bc);
        logic [AW-1:0] base;
        base = {addr[AW-1:6], 6'b0};
        for (int n = 0; n < int'(bc); n++) begin
            exp_addr_q.push_back(base + AW'(n * 64));
            exp_sub_q.push_back(IW'(n));
        end
        tick(1);
        start       = 1'b1;
        start_addr  = addr;
        burst_count = bc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge fsabi_clk);
            k++;
        end while (done !== 1'b1 && k < budget);
        if (done !== 1'b1) fail_now({name, "_timeout"});
        else begin
            check({name, "_gap"}, 64'(cyc - last_beat_cyc), 64'd1);
            check({name, "_busy"}, 64'(busy), 64'd1);
            @(negedge fsabi_clk);
            check({name, "_pulse"}, 64'({busy, done}), 64'd0);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, 64'({busy, done, fsabo_valid, out_valid}), 64'd0);
        check({name, "_fsabo"}, 64'({fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len}),
              64'd0);
        check({name, "_outdata"}, out_data, 64'd0);
    endtask

    initial begin
        int r0, k;
        // Reset state.
        repeat (3) @(negedge fsabi_clk);
        check_reset_outputs("reset");
        tick(1);
        rst_b = 1'b1;
        tick(2);

        // Single burst, streaming consumer.
        auto_credit = 1'b1;
        out_ready   = 1'b1;
        r0 = req_seen;
        do_start(31'h1000, 16'd1);
        wait_done("single", 100);
        tick(3);
        check("single_reqs", 64'(req_seen - r0), 64'd1);
        check("single_drained", 64'(exp_q.size()), 64'd0);

        // No credits returned: four requests then stall; start while busy is ignored.
        auto_credit = 1'b0;
        r0 = req_seen;
        do_start(31'h1000, 16'd6);
        tick(40);
        check("stall_reqs", 64'(req_seen - r0), 64'd4);
        check("stall_busy", 64'(busy), 64'd1);
        start = 1'b1; start_addr = 31'h8000; burst_count = 16'd3;
        tick(1);
        start = 1'b0;
        tick(10);
        credit_grant++;
        tick(6);
        check("credit_fifth", 64'(req_seen - r0), 64'd5);
        credit_grant++;
        wait_done("stall", 200);
        tick(2);
        check("stall_total", 64'(req_seen - r0), 64'd6);
        credit_grant += 4;
        tick(8);

        // Credit returned in the same cycle as the first request.
        same_req++;
        r0 = req_seen;
        do_start(31'h3000, 16'd6);
        tick(40);
        check("same_cycle_reqs", 64'(req_seen - r0), 64'd5);
        credit_grant++;
        wait_done("same_cycle", 200);
        credit_grant += 4;
        tick(8);

        // Consumer stalled: only FIFO_DEPTH words may be reserved.
        auto_credit = 1'b1;
        out_ready   = 1'b0;
        r0 = req_seen;
        do_start(31'h4000, 16'd8);
        tick(60);
        check("backpr_reqs", 64'(req_seen - r0), 64'd4);
        check("backpr_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick(7);
        out_ready = 1'b0;
        tick(10);
        check("backpr_7pops", 64'(req_seen - r0), 64'd4);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(5);
        check("backpr_8pops", 64'(req_seen - r0), 64'd5);
        out_ready = 1'b1;
        wait_done("backpr", 400);
        tick(2);
        check("backpr_total", 64'(req_seen - r0), 64'd8);

        // Foreign-ID beats interleaved; unaligned start address.
        junk_mode = 1'b1;
        r0 = req_seen;
        do_start(31'h2025, 16'd2);
        wait_done("junk", 200);
        junk_mode = 1'b0;
        tick(3);
        check("junk_reqs", 64'(req_seen - r0), 64'd2);
        check("junk_drained", 64'(exp_q.size()), 64'd0);

        // Zero-length job.
        r0 = req_seen;
        tick(1);
        start = 1'b1; start_addr = 31'h7000; burst_count = 16'd0;
        @(negedge fsabi_clk);
        check("zero_c0", 64'({busy, done}), 64'd0);
        tick(1);
        start = 1'b0;
        @(negedge fsabi_clk);
        check("zero_c1", 64'({busy, done}), 64'b11);
        @(negedge fsabi_clk);
        check("zero_c2", 64'({busy, done}), 64'd0);
        tick(5);
        check("zero_reqs", 64'(req_seen - r0), 64'd0);

        // Reset mid-job after 2 requests and 5 beats.
        out_ready   = 1'b0;
        resp_budget = resp_sent + 5;
        r0 = req_seen;
        do_start(31'h5000, 16'd2);
        k = 0;
        while (resp_sent < resp_budget && k < 50) begin tick(1); k++; end
        check("midrst_beats", 64'(resp_sent - (resp_budget - 5)), 64'd5);
        tick(3);
        check("midrst_reqs", 64'(req_seen - r0), 64'd2);
        rst_b = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        stale_mode  = 1'b1;
        resp_budget = 1000000;
        tick(2);
        rst_b = 1'b1;
        k = 0;
        while (pend_q.size() > 0 && k < 40) begin tick(1); k++; end
        check("stale_all_sent", 64'(pend_q.size()), 64'd0);
        tick(3);
        check("stale_dropped", 64'({out_valid, busy}), 64'd0);
        stale_mode  = 1'b0;
        auto_credit = 1'b0;
        out_ready   = 1'b1;
        tick(2);
        r0 = req_seen;
        do_start(31'h6000, 16'd5);
        tick(40);
        check("postrst_credits", 64'(req_seen - r0), 64'd4);
        credit_grant++;
        wait_done("postrst", 200);
        credit_grant += 4;
        tick(10);

        check("end_exp_req_empty", 64'(exp_addr_q.size()), 64'd0);
        check("end_exp_data_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_bad);
        $fatal(1, "watchdog");
    end

endmodule
